snitch_icache_refill_arb: RTL
=============================

SNITCH_ICACHE_REFILL_ARB -- requirements
Module: snitch_icache_refill_arb

Interface
REQ-001 SHALL have parameter NrPorts, default 4, number of L0 requesters (>=2).
REQ-002 SHALL have parameter AddrWidth, default 32, fetch address width.
REQ-003 SHALL have parameter LineWidth, default 128, cache line bits.
REQ-004 SHALL derive LineAlign = clog2(LineWidth/8) and IdWidth = clog2(NrPorts).
REQ-005 SHALL have ports; clk_i and rst_ni come first:
  clk_i  in  1  sole clock, rising edge
  rst_ni  in  1  reset, synchronous, active-low
  in_addr_i  in  NrPorts x AddrWidth  per-port miss address
  in_valid_i / in_ready_o  in/out  NrPorts  per-port request handshake
  in_rsp_data_o  out  LineWidth  shared response line
  in_rsp_error_o  out  1  response error
  in_rsp_valid_o / in_rsp_ready_i  out/in  NrPorts  per-port response handshake
  out_addr_o  out  AddrWidth  line-aligned refill address
  out_id_o  out  IdWidth  refill ID (= issuing port index)
  out_valid_o / out_ready_i  out/in  1  refill request handshake
  out_rsp_data_i  in  LineWidth  refill line
  out_rsp_id_i  in  IdWidth  refill response ID
  out_rsp_error_i  in  1  refill error
  out_rsp_valid_i / out_rsp_ready_o  in/out  1  refill response handshake
  merged_o  out  NrPorts  one-cycle pulse when port coalesced
  spurious_o  out  1  one-cycle pulse on response to non-issued ID

Function
REQ-006 SHALL keep a per-port FSM: IDLE, PEND, ISSUED, MERGED, RESP.
REQ-007 SHALL drive in_ready_o[p] = (state[p]==IDLE); on handshake, latch in_addr_i[p], go to PEND.
REQ-008 SHALL compare line addresses only: bits [AddrWidth-1:LineAlign].
REQ-009 In PEND, SHALL check for any port q in ISSUED with equal line address; on match, go to MERGED, record leader q, pulse merged_o[p]; the merge check has priority over arbitration.
REQ-010 PEND ports with no match SHALL arbitrate round-robin: grant lowest index >= rr_ptr, wrap-around to 0.
REQ-011 SHALL drive out_valid_o whenever a grant exists, with out_addr_o = latched address with low LineAlign bits zeroed, and out_id_o = granted index.
REQ-012 While out_valid_o && !out_ready_i, SHALL hold the grant, out_addr_o and out_id_o stable; new PEND ports SHALL NOT preempt it.
REQ-013 On out handshake, granted port SHALL go to ISSUED, and rr_ptr SHALL become (grant+1) mod NrPorts.
REQ-014 Two PEND ports with the same line in one cycle: one SHALL issue; the other SHALL merge the next cycle, never issue.
REQ-015 SHALL hold a one-entry response buffer: data, error, target mask; out_rsp_ready_o = (mask==0).
REQ-016 On out_rsp handshake with ID k and state[k]==ISSUED, the mask SHALL be set to port k plus all MERGED ports with leader k; those ports go to RESP.
REQ-017 On out_rsp handshake with state[k]!=ISSUED, SHALL discard the response, leave the mask zero, and pulse spurious_o.
REQ-018 SHALL drive in_rsp_valid_o[p] = mask[p], with buffered data/error broadcast on in_rsp_data_o/in_rsp_error_o.
REQ-019 On in_rsp handshake, SHALL clear mask[p] and move port p from RESP to IDLE; ports clear independently.
REQ-020 Response latency from out_rsp handshake to in_rsp_valid_o SHALL be exactly 1 cycle.
REQ-021 Error responses SHALL be routed identically to normal responses; no retry.
REQ-022 Responses MAY arrive out of order relative to issue order.

Reset
REQ-023 With rst_ni low at a clock edge: all FSMs to IDLE, mask 0, rr_ptr 0, grant lock cleared.
REQ-024 Reset values: in_ready_o all 1; out_valid_o 0; out_rsp_ready_o 1; in_rsp_valid_o 0; merged_o 0; spurious_o 0.
REQ-025 Reset mid-operation SHALL drop all pending/issued/buffered state; a response arriving afterwards SHALL be treated as spurious.

Verification
REQ-026 Port 0 requests 0x1004, out_ready_i=1 -> out_addr_o=0x1000, out_id_o=0 issued; response id 0, data 0xA5.. -> in_rsp_valid_o[0] next cycle, data 0xA5...
REQ-027 Ports 0-3 request 0x100,0x200,0x300,0x400 in the same cycle, out_ready_i=1 -> IDs 0,1,2,3 issued on consecutive cycles, rr_ptr=0 afterwards.
REQ-028 Ports 1,2 request 0x2004,0x2008 together -> single issue id 1, merged_o[2] pulses; response id 1 -> in_rsp_valid_o=4'b0110 same cycle.
REQ-029 Ports 0,3 pending, out_ready_i low 5 cycles -> out_addr_o/out_id_o constant; ID 0 issued first, then ID 3.
REQ-030 in_rsp_ready_i[0] low 3 cycles while buffer full -> out_rsp_ready_o low 3 cycles; second response accepted the cycle after mask clears.
REQ-031 Response id 2 while port 2 IDLE -> spurious_o pulse, no in_rsp_valid_o; reset while port 1 ISSUED -> in_ready_o=4'b1111 next cycle.

Source files
------------

// File: rtl/snitch_icache_refill_arb.sv
// Refill arbiter for the Snitch L0 instruction caches: coalesces same-line misses,
// issues one refill per line round-robin and fans the returned line out to waiting ports.
`timescale 1ns/1ps
module snitch_icache_refill_arb #(
    parameter int unsigned NrPorts   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LineWidth = 128,
    localparam int unsigned LineAlign = $clog2(LineWidth / 8),
    localparam int unsigned IdWidth   = $clog2(NrPorts)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NrPorts-1:0][AddrWidth-1:0]  in_addr_i,
    input  logic [NrPorts-1:0]                 in_valid_i,
    output logic [NrPorts-1:0]                 in_ready_o,
    output logic [LineWidth-1:0]               in_rsp_data_o,
    output logic                               in_rsp_error_o,
    output logic [NrPorts-1:0]                 in_rsp_valid_o,
    input  logic [NrPorts-1:0]                 in_rsp_ready_i,
    output logic [AddrWidth-1:0]               out_addr_o,
    output logic [IdWidth-1:0]                 out_id_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    input  logic [LineWidth-1:0]               out_rsp_data_i,
    input  logic [IdWidth-1:0]                 out_rsp_id_i,
    input  logic                               out_rsp_error_i,
    input  logic                               out_rsp_valid_i,
    output logic                               out_rsp_ready_o,
    output logic [NrPorts-1:0]                 merged_o,
    output logic                               spurious_o
);

    localparam logic [AddrWidth-1:0] AlignMask = {AddrWidth{1'b1}} << LineAlign;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        ISSUED = 3'd2,
        MERGED = 3'd3,
        RESP   = 3'd4
    } port_state_e;

    port_state_e                state_q  [NrPorts];
    port_state_e                state_d  [NrPorts];
    logic [AddrWidth-1:0]       addr_q   [NrPorts];
    logic [AddrWidth-1:0]       addr_d   [NrPorts];
    logic [IdWidth-1:0]         leader_q [NrPorts];
    logic [IdWidth-1:0]         leader_d [NrPorts];

    logic [NrPorts-1:0]         mask_q, mask_d;
    logic [LineWidth-1:0]       data_q, data_d;
    logic                       error_q, error_d;
    logic [IdWidth-1:0]         rr_q, rr_d;
    logic                       lock_q, lock_d;
    logic [IdWidth-1:0]         lock_id_q, lock_id_d;
    logic [NrPorts-1:0]         merged_q, merged_d;
    logic                       spurious_q, spurious_d;

    logic [NrPorts-1:0]         merge_hit;
    logic [IdWidth-1:0]         merge_ldr [NrPorts];
    logic [NrPorts-1:0]         eligible;
    logic                       gnt_valid;
    logic [IdWidth-1:0]         gnt_id;
    logic                       out_hs;
    logic                       rsp_hs;
    logic                       rsp_hit;

    // Merge detection; a port holding a locked grant is committed to issuing.
    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            merge_hit[p] = 1'b0;
            merge_ldr[p] = '0;
            eligible[p]  = 1'b0;
            if (state_q[p] == PEND && !(lock_q && lock_id_q == IdWidth'(p))) begin
                for (int q = 0; q < NrPorts; q++) begin
                    if (!merge_hit[p] && state_q[q] == ISSUED &&
                        addr_q[q][AddrWidth-1:LineAlign] == addr_q[p][AddrWidth-1:LineAlign]) begin
                        merge_hit[p] = 1'b1;
                        merge_ldr[p] = IdWidth'(q);
                    end
                end
            end
            eligible[p] = (state_q[p] == PEND) && !merge_hit[p];
        end
    end

    // Round-robin grant: lowest eligible index at or above rr_q, then wrap.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                if (!gnt_valid && eligible[p] && IdWidth'(p) >= rr_q) begin
                    gnt_valid = 1'b1;
                    gnt_id    = IdWidth'(p);
                end
            end
            for (int p = 0; p < NrPorts; p++) begin
                if (!gnt_valid && eligible[p] && IdWidth'(p) < rr_q) begin
                    gnt_valid = 1'b1;
                    gnt_id    = IdWidth'(p);
                end
            end
        end
    end

    assign out_valid_o     = gnt_valid;
    assign out_id_o        = gnt_id;
    assign out_addr_o      = addr_q[gnt_id] & AlignMask;
    assign out_hs          = gnt_valid && out_ready_i;
    assign out_rsp_ready_o = (mask_q == '0);
    assign rsp_hs          = out_rsp_valid_i && out_rsp_ready_o;

    always_comb begin
        rsp_hit = 1'b0;
        for (int p = 0; p < NrPorts; p++) begin
            if (out_rsp_id_i == IdWidth'(p) && state_q[p] == ISSUED) rsp_hit = 1'b1;
        end
    end

    // Next-state for port FSMs, response buffer and arbitration pointer.
    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            state_d[p]  = state_q[p];
            addr_d[p]   = addr_q[p];
            leader_d[p] = leader_q[p];
        end
        mask_d     = mask_q;
        data_d     = data_q;
        error_d    = error_q;
        rr_d       = rr_q;
        lock_d     = gnt_valid && !out_ready_i;
        lock_id_d  = gnt_id;
        merged_d   = '0;
        spurious_d = 1'b0;

        for (int p = 0; p < NrPorts; p++) begin
            case (state_q[p])
                IDLE: begin
                    if (in_valid_i[p]) begin
                        state_d[p] = PEND;
                        addr_d[p]  = in_addr_i[p];
                    end
                end
                PEND: begin
                    if (merge_hit[p]) begin
                        state_d[p]  = MERGED;
                        leader_d[p] = merge_ldr[p];
                        merged_d[p] = 1'b1;
                    end else if (out_hs && gnt_id == IdWidth'(p)) begin
                        state_d[p] = ISSUED;
                    end
                end
                RESP: begin
                    if (mask_q[p] && in_rsp_ready_i[p]) begin
                        state_d[p] = IDLE;
                        mask_d[p]  = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (out_hs) begin
            rr_d = (gnt_id == IdWidth'(NrPorts - 1)) ? '0 : gnt_id + IdWidth'(1);
        end

        // Ports merging in this very cycle still belong to the returning line.
        if (rsp_hs) begin
            if (rsp_hit) begin
                data_d  = out_rsp_data_i;
                error_d = out_rsp_error_i;
                for (int p = 0; p < NrPorts; p++) begin
                    if ((state_q[p] == ISSUED && out_rsp_id_i == IdWidth'(p)) ||
                        (state_q[p] == MERGED && leader_q[p] == out_rsp_id_i) ||
                        (merge_hit[p] && merge_ldr[p] == out_rsp_id_i)) begin
                        mask_d[p]  = 1'b1;
                        state_d[p] = RESP;
                    end
                end
            end else begin
                spurious_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NrPorts; p++) begin
                state_q[p]  <= IDLE;
                addr_q[p]   <= '0;
                leader_q[p] <= '0;
            end
            mask_q     <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            merged_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                state_q[p]  <= state_d[p];
                addr_q[p]   <= addr_d[p];
                leader_q[p] <= leader_d[p];
            end
            mask_q     <= mask_d;
            data_q     <= data_d;
            error_q    <= error_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            merged_q   <= merged_d;
            spurious_q <= spurious_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            in_ready_o[p] = (state_q[p] == IDLE);
        end
    end

    assign in_rsp_valid_o = mask_q;
    assign in_rsp_data_o  = data_q;
    assign in_rsp_error_o = error_q;
    assign merged_o       = merged_q;
    assign spurious_o     = spurious_q;

endmodule
